// File: rtl/regression_sample_feeder.sv
// Sample buffer and replay sequencer for the regression coefficient calculator.
// Fills N (x,y) pairs, then replays the set NUM_PASSES times on rd_req.
module regression_sample_feeder #(
  parameter int DATA_W     = 20,
  parameter int DEPTH      = 150,
  parameter int NUM_PASSES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_x,
  input  logic [DATA_W-1:0]            wr_y,
  input  logic                         seal,
  input  logic                         rd_req,
  output logic [DATA_W-1:0]            x_out,
  output logic [DATA_W-1:0]            y_out,
  output logic                         co,
  output logic                         start,
  output logic [1:0]                   pass,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow,
  output logic                         done
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam logic [1:0] NP = 2'(NUM_PASSES);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [2*DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]        pass_q, pass_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              co_q, co_d;
  logic              start_q, start_d;
  logic              ovf_q, ovf_d;

  logic              full_w;
  logic              wr_ok;
  logic              last;
  logic [2*DATA_W-1:0] rd_word;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign wr_ok   = (state_q == S_FILL) && wr_en && !full_w;
  assign last    = (CNT_W'(rd_ptr_q) == count_q - CNT_W'(1));
  assign rd_word = mem[rd_ptr_q];

  // Next-state logic: clear dominates, then per-state fill/stream handling
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    pass_d   = pass_q;
    x_d      = x_q;
    y_d      = y_q;
    co_d     = co_q;
    start_d  = 1'b0;
    ovf_d    = ovf_q;
    if (clear) begin
      state_d  = S_FILL;
      count_d  = '0;
      rd_ptr_d = '0;
      pass_d   = '0;
      co_d     = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (wr_en) begin
            if (full_w) ovf_d = 1'b1;
            else count_d = count_q + CNT_W'(1);
          end
          if (seal && count_d != '0) begin
            state_d  = S_STREAM;
            rd_ptr_d = '0;
            pass_d   = '0;
            start_d  = 1'b1;
          end
        end
        S_STREAM: begin
          if (rd_req) begin
            x_d  = rd_word[2*DATA_W-1:DATA_W];
            y_d  = rd_word[DATA_W-1:0];
            co_d = last;
            if (last) begin
              rd_ptr_d = '0;
              pass_d   = pass_q + 2'd1;
              if (pass_q + 2'd1 == NP) state_d = S_DONE;
            end else begin
              rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_FILL;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FILL;
      count_q  <= '0;
      rd_ptr_q <= '0;
      pass_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      co_q     <= 1'b0;
      start_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      pass_q   <= pass_d;
      x_q      <= x_d;
      y_q      <= y_d;
      co_q     <= co_d;
      start_q  <= start_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sample RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_ok)
      mem[count_q[ADDR_W-1:0]] <= {wr_x, wr_y};
  end

  assign x_out    = x_q;
  assign y_out    = y_q;
  assign co       = co_q;
  assign start    = start_q;
  assign pass     = pass_q;
  assign count    = count_q;
  assign full     = full_w;
  assign overflow = ovf_q;
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_regression_sample_feeder.sv
// Directed bench for regression_sample_feeder.
// Linear stimulus with immediate-assertion checks at each step.
module tb_regression_sample_feeder;

  localparam int DW = 20;
  localparam int DEPTH = 150;

  logic          clk = 1'b0;
  logic          rst, clear, wr_en, seal, rd_req;
  logic [DW-1:0] wr_x, wr_y;
  logic [DW-1:0] x_out, y_out;
  logic          co, start, full, overflow, done;
  logic [1:0]    pass;
  logic [7:0]    count;

  int vecs = 0;
  int miss = 0;

  regression_sample_feeder dut (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .seal(seal), .rd_req(rd_req),
    .x_out(x_out), .y_out(y_out), .co(co),
    .start(start), .pass(pass), .count(count),
    .full(full), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int x, input int y);
    wr_en = 1'b1;
    wr_x  = DW'(x);
    wr_y  = DW'(y);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_seal();
    seal = 1'b1;
    tick();
    seal = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic rd();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    int ex1 [6] = '{1, 3, 5, 1, 3, 5};
    int ey1 [6] = '{2, 4, 6, 2, 4, 6};
    int ec1 [6] = '{0, 0, 1, 0, 0, 1};
    int ep1 [6] = '{0, 0, 1, 1, 1, 2};
    int bad;
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; seal = 1'b0;
    rd_req = 1'b0; wr_x = '0; wr_y = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_x", x_out, 0);
    chk("rst_co", co, 0);
    chk("rst_start", start, 0);
    chk("rst_pass", pass, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", done, 0);

    // basic fill and two-pass replay
    wr(1, 2); wr(3, 4); wr(5, 6);
    chk("s1_count", count, 3);
    do_seal();
    chk("s1_start", start, 1);
    tick();
    chk("s1_start_off", start, 0);
    for (int i = 0; i < 6; i++) begin
      rd();
      chk($sformatf("s1_x%0d", i), x_out, ex1[i]);
      chk($sformatf("s1_y%0d", i), y_out, ey1[i]);
      chk($sformatf("s1_co%0d", i), co, ec1[i]);
      chk($sformatf("s1_pass%0d", i), pass, ep1[i]);
      chk($sformatf("s1_done%0d", i), done, (i == 5) ? 1 : 0);
    end
    rd();
    chk("s1_hold_x", x_out, 5);
    chk("s1_hold_co", co, 1);
    chk("s1_hold_done", done, 1);

    // seal on empty buffer is ignored
    do_clear();
    chk("clr_count", count, 0);
    chk("clr_done", done, 0);
    chk("clr_co", co, 0);
    chk("clr_pass", pass, 0);
    do_seal();
    chk("s3_start", start, 0);
    rd();
    chk("s3_co", co, 0);
    chk("s3_pass", pass, 0);
    chk("s3_done", done, 0);
    chk("s3_start2", start, 0);

    // write+seal same cycle, single-sample set
    wr_en = 1'b1; seal = 1'b1; wr_x = 7; wr_y = 8;
    tick();
    wr_en = 1'b0; seal = 1'b0;
    chk("s4_count", count, 1);
    chk("s4_start", start, 1);
    rd();
    chk("s4_x", x_out, 7);
    chk("s4_y", y_out, 8);
    chk("s4_co", co, 1);
    chk("s4_pass", pass, 1);
    rd();
    chk("s4_x2", x_out, 7);
    chk("s4_co2", co, 1);
    chk("s4_done", done, 1);

    // clear mid-stream, then new fill
    do_clear();
    wr(1, 2); wr(3, 4); wr(5, 6);
    do_seal();
    rd(); rd();
    chk("s5_pre_x", x_out, 3);
    do_clear();
    chk("s5_count", count, 0);
    chk("s5_pass", pass, 0);
    chk("s5_co", co, 0);
    chk("s5_done", done, 0);
    tick();
    chk("s5_nostart", start, 0);
    wr(9, 10); wr(11, 12);
    do_seal();
    chk("s5_start", start, 1);
    for (int i = 0; i < 4; i++) begin
      rd();
      chk($sformatf("s5_x%0d", i), x_out, (i % 2 == 0) ? 9 : 11);
      chk($sformatf("s5_y%0d", i), y_out, (i % 2 == 0) ? 10 : 12);
      chk($sformatf("s5_co%0d", i), co, i % 2);
    end
    chk("s5_done", done, 1);

    // rd_req every 3rd cycle gives same sequence and holds
    do_clear();
    wr(1, 2); wr(3, 4); wr(5, 6);
    do_seal();
    for (int i = 0; i < 6; i++) begin
      rd();
      chk($sformatf("s6_x%0d", i), x_out, ex1[i]);
      chk($sformatf("s6_co%0d", i), co, ec1[i]);
      tick(); tick();
      chk($sformatf("s6_hx%0d", i), x_out, ex1[i]);
      chk($sformatf("s6_hy%0d", i), y_out, ey1[i]);
      chk($sformatf("s6_hco%0d", i), co, ec1[i]);
    end
    chk("s6_done", done, 1);

    // full buffer and overflow
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      wr(i, i + 1000);
      if (i == DEPTH - 2) chk("s2_notfull", full, 0);
    end
    chk("s2_count", count, DEPTH);
    chk("s2_full", full, 1);
    chk("s2_ovf0", overflow, 0);
    wr(999, 999);
    chk("s2_count2", count, DEPTH);
    chk("s2_ovf1", overflow, 1);
    do_seal();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rd();
      if (x_out !== DW'(i) || y_out !== DW'(i + 1000)) bad++;
      if (co !== ((i == DEPTH - 1) ? 1'b1 : 1'b0)) bad++;
    end
    chk("s2_replay_errs", bad, 0);
    chk("s2_last_x", x_out, DEPTH - 1);
    chk("s2_pass", pass, 1);
    rd();
    chk("s2_wrap_x", x_out, 0);
    chk("s2_wrap_co", co, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
